// File: rtl/fifo2axis.sv
// fifo2axis: drains a 1-cycle-latency FIFO into one AXI-Stream frame of a programmed length.
// Build macro FIFO2AXIS_AUTO_RESTART_EN: one-cycle DONE and back-to-back frames while en_i stays high.
module fifo2axis #(
    parameter int DATA_W     = 32,
    parameter int AXIS_LEN_W = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic [AXIS_LEN_W-1:0] len_i,
    output logic [AXIS_LEN_W-1:0] len_o,
    output logic                  done_o,
    input  logic                  fifo_empty_i,
    output logic                  fifo_read_o,
    input  logic [DATA_W-1:0]     fifo_rdata_i,
    output logic [DATA_W-1:0]     axis_tdata_o,
    output logic                  axis_tvalid_o,
    input  logic                  axis_tready_i,
    output logic                  axis_tlast_o
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [AXIS_LEN_W-1:0] LEN_ONE  = {{(AXIS_LEN_W-1){1'b0}}, 1'b1};
    localparam logic [AXIS_LEN_W-1:0] LEN_ZERO = {AXIS_LEN_W{1'b0}};

    state_t                state_q, state_d;
    logic [AXIS_LEN_W-1:0] len_reg_q, len_reg_d;
    logic [AXIS_LEN_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [AXIS_LEN_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [DATA_W-1:0]     buf0_q, buf0_d, buf1_q, buf1_d;
    logic [1:0]            occ_q, occ_d;
    logic                  pend_q, pend_d;
    logic                  pop_s, last_beat_s, read_s, start_s;

    assign pop_s       = (occ_q != 2'd0) & axis_tready_i;
    assign last_beat_s = (beat_cnt_q == (len_reg_q - LEN_ONE));
    // occ+pend-pop<2, rearranged to stay unsigned
    assign read_s = (state_q == ST_RUN) & en_i & ~fifo_empty_i & (rd_cnt_q < len_reg_q) &
                    (({1'b0, occ_q} + {2'b00, pend_q}) < (3'd2 + {2'b00, pop_s}));

    assign fifo_read_o   = read_s;
    assign axis_tvalid_o = (occ_q != 2'd0);
    assign axis_tdata_o  = buf0_q;
    assign axis_tlast_o  = (occ_q != 2'd0) & last_beat_s;
    assign done_o        = (state_q == ST_DONE);
    assign len_o         = beat_cnt_q;

    // Frame sequencing and the read/beat counters
    always_comb begin
        state_d    = state_q;
        len_reg_d  = len_reg_q;
        rd_cnt_d   = rd_cnt_q;
        beat_cnt_d = beat_cnt_q;
        start_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en_i) begin
                    start_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (pop_s && last_beat_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
`ifdef FIFO2AXIS_AUTO_RESTART_EN
                if (en_i) begin
                    start_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
`else
                if (!en_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (start_s) begin
            len_reg_d  = len_i;
            rd_cnt_d   = LEN_ZERO;
            beat_cnt_d = LEN_ZERO;
            if (len_i != LEN_ZERO) begin
                state_d = ST_RUN;
            end else begin
                state_d = ST_DONE;
            end
        end else begin
            if (read_s) begin
                rd_cnt_d = rd_cnt_q + LEN_ONE;
            end else begin
                rd_cnt_d = rd_cnt_q;
            end
            if (pop_s) begin
                beat_cnt_d = beat_cnt_q + LEN_ONE;
            end else begin
                beat_cnt_d = beat_cnt_q;
            end
        end
    end

    // Two-entry output buffer: returning word pushes at the tail, accepted beat pops the head
    always_comb begin
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        occ_d  = occ_q;
        pend_d = read_s;
        case ({pend_q, pop_s})
            2'b01: begin
                buf0_d = buf1_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b10: begin
                if (occ_q == 2'd0) begin
                    buf0_d = fifo_rdata_i;
                end else begin
                    buf1_d = fifo_rdata_i;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd2) begin
                    buf0_d = buf1_q;
                    buf1_d = fifo_rdata_i;
                end else begin
                    buf0_d = fifo_rdata_i;
                end
            end
            default: begin
                occ_d = occ_q;
            end
        endcase
    end

    // State and datapath registers; reset discards any buffered or in-flight word
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            len_reg_q  <= LEN_ZERO;
            rd_cnt_q   <= LEN_ZERO;
            beat_cnt_q <= LEN_ZERO;
            buf0_q     <= {DATA_W{1'b0}};
            buf1_q     <= {DATA_W{1'b0}};
            occ_q      <= 2'd0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_reg_q  <= len_reg_d;
            rd_cnt_q   <= rd_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            occ_q      <= occ_d;
            pend_q     <= pend_d;
        end
    end
endmodule

// File: doc/fifo2axis.md
Name: fifo2axis

Overview:
- Transmit-side counterpart of the AXIS-to-FIFO receiver.
- Drains a synchronous FIFO (1-cycle read latency) and emits one AXI-Stream frame of a programmed length.
- Asserts tlast on the final beat and reports completion.
- Sits between a FIFO read port and an AXIS master interface feeding DMA/peripheral datapaths.

Parameters:
DATA_W, 32, width of FIFO read data and axis_tdata_o
AXIS_LEN_W, 16, width of frame length and beat counter

Ports:
clk_i  input  1  system clock; all logic on rising edge
rst_i  input  1  reset; synchronous, active-high
en_i  input  1  enable; frame starts when high in IDLE
len_i  input  AXIS_LEN_W  frame length in beats, sampled at frame start
len_o  output  AXIS_LEN_W  beats accepted downstream in current frame
done_o  output  1  frame complete
fifo_empty_i  input  1  FIFO empty flag
fifo_read_o  output  1  FIFO read strobe
fifo_rdata_i  input  DATA_W  FIFO data, valid the cycle after fifo_read_o
axis_tdata_o  output  DATA_W  stream data
axis_tvalid_o  output  1  stream valid
axis_tready_i  input  1  stream ready
axis_tlast_o  output  1  last beat of frame

Behaviour:
- Reset (rst_i=1 at clock edge): state IDLE; all outputs 0. Counters, len register and 2-entry output buffer are cleared. Buffered and in-flight words are discarded; this applies mid-frame too.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN when en_i=1 and len_i!=0. len_i is latched into len_reg; rd_cnt and len_o are cleared.
  - IDLE -> DONE when en_i=1 and len_i=0. No FIFO reads and no beats are produced.
  - RUN -> DONE on the cycle the beat with len_o==len_reg-1 is accepted (tvalid&tready).
  - DONE -> IDLE when en_i=0.
- done_o=1 exactly while in DONE.
- Buffer: 2-entry skid/FIFO. occ = entries held; pend = 1 if a read was issued last cycle. A returning word is written into the buffer the cycle after fifo_read_o.
- pop = axis_tvalid_o & axis_tready_i.
- fifo_read_o is high only when all of these hold:
  - state==RUN and en_i=1
  - fifo_empty_i=0
  - rd_cnt<len_reg
  - occ+pend-pop<2
- rd_cnt increments on each read; it never exceeds len_reg, so no word of the next frame is consumed.
- Throughput: 1 beat/cycle sustained with FIFO non-empty and tready=1. First-beat latency is 2 cycles from the RUN entry edge.
- axis_tvalid_o = (occ!=0). axis_tdata_o = buffer head.
- axis_tlast_o = tvalid & (len_o==len_reg-1).
- AXIS rules:
  - Once tvalid is asserted, tvalid, tdata and tlast hold stable until accepted.
  - tvalid never depends combinationally on tready.
  - fifo_read_o does depend combinationally on tready via pop.
- len_o increments on each pop; it holds its final value (=len_reg) in DONE and is cleared on the next frame start.
- en_i=0 during RUN pauses new reads only. In-flight and buffered words still drain. Counters are kept, and the frame resumes when en_i returns to 1. Only rst_i aborts a frame.
- len_i changes during RUN are ignored.
- Width rule: len_reg max 2^AXIS_LEN_W-1; counters never wrap within a frame.
- fifo_empty_i rising mid-frame: reads stall, tvalid drops after the buffer drains, no beat is duplicated.

Optional Feature:
- Macro FIFO2AXIS_AUTO_RESTART_EN.
- Defined:
  - DONE lasts exactly one cycle, so done_o is a 1-cycle pulse per frame.
  - If en_i=1 in DONE, len_i is re-latched and the FSM goes to RUN (or DONE again if len_i=0); if en_i=0 it goes to IDLE.
  - Back-to-back frames have a 1-cycle gap between tlast acceptance and the next read.
- Undefined: DONE holds until en_i=0, as specified above.

Test Plan:
- Basic frame: len_i=4, FIFO holds A,B,C,D, tready=1, en_i held high -> beats A,B,C,D on 4 consecutive cycles; tlast only with D; exactly 4 fifo_read_o pulses; len_o=4; done_o=1 until en_i=0.
- Backpressure: len_i=6, tready toggles 1,0,0,1 pattern -> tdata/tlast stable while tvalid&~tready; no loss or duplication; occupancy never above 2; 6 reads total.
- FIFO underrun: len_i=5, FIFO has 2 words, 3 more written 10 cycles later -> tvalid low during gap; all 5 beats in order; tlast on 5th.
- Zero length and overrun guard:
  - len_i=0 -> no reads; done_o=1 on the cycle after en_i rises.
  - len_i=3 with 8 words in FIFO -> exactly 3 reads; 5 words remain.
- Pause and reset:
  - en_i dropped after beat 2 of 8 -> reads stop; buffered words drain; resuming en_i completes beats 3-8 with tlast on 8.
  - rst_i pulsed at beat 3 -> next cycle tvalid=0, len_o=0, done_o=0, state IDLE.
- Macro FIFO2AXIS_AUTO_RESTART_EN, en_i held 1, len_i=2, 6 words -> three frames of 2 beats; three 1-cycle done_o pulses; tlast on beats 2, 4, 6.
